// File: rtl/i2c_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_slave_port
// Brief    : Byte-level I2C target, bus bytes <-> CLK-domain byte stream.
//            Define I2C_SLAVE_MSB_FIRST_EN for standard MSB-first bit order.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_port #(
    parameter int                       ADDRESSLENGTH = 7,
    parameter logic [ADDRESSLENGTH-1:0] SLAVE_ADDR    = 7'h2A
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_RW        = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_RX_BYTE   = 4'd4,
        S_RX_ACK    = 4'd5,
        S_TX_BYTE   = 4'd6,
        S_TX_ACK    = 4'd7,
        S_WAIT_STOP = 4'd8
    } state_t;

    localparam logic [3:0] c_ADDR_LAST = 4'(ADDRESSLENGTH - 1);

    // [0],[1] synchroniser, [2] history
    logic [2:0] r_scl_sync, r_sda_sync;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_bit;

    state_t                   r_state, w_state;
    logic [3:0]               r_cnt, w_cnt, w_cnt_inc;
    logic [ADDRESSLENGTH-1:0] r_addr, w_addr, w_addr_shift;
    logic [7:0]               r_rx, w_rx, w_rx_shift;
    logic [7:0]               r_tx, w_tx;
    logic [2:0]               w_tx_idx;
    logic                     r_rw, w_rw;
    logic                     r_oe, w_oe;
    logic                     r_ack_on, w_ack_on;
    logic [7:0]               r_wr_data, w_wr_data;
    logic                     r_wr_pend, w_wr_pend, r_wr_valid;
    logic                     r_rd_arm, w_rd_arm, r_rd_req;
    logic                     r_busy, w_busy;

    assign w_scl_rise = r_scl_sync[1] & ~r_scl_sync[2];
    assign w_scl_fall = ~r_scl_sync[1] & r_scl_sync[2];
    assign w_start    = r_scl_sync[1] & r_scl_sync[2] & ~r_sda_sync[1] & r_sda_sync[2];
    assign w_stop     = r_scl_sync[1] & r_scl_sync[2] & r_sda_sync[1] & ~r_sda_sync[2];
    // the history FF holds the level that produced the registered event
    assign w_bit      = r_sda_sync[2];
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

`ifdef I2C_SLAVE_MSB_FIRST_EN
    assign w_addr_shift = {r_addr[ADDRESSLENGTH-2:0], w_bit};
    assign w_rx_shift   = {r_rx[6:0], w_bit};
    assign w_tx_idx     = 3'd7 - r_cnt[2:0];
`else
    assign w_addr_shift = {w_bit, r_addr[ADDRESSLENGTH-1:1]};
    assign w_rx_shift   = {w_bit, r_rx[7:1]};
    assign w_tx_idx     = r_cnt[2:0];
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '1;
            r_rx       <= 8'hFF;
            r_tx       <= 8'h00;
            r_rw       <= 1'b0;
            r_oe       <= 1'b0;
            r_ack_on   <= 1'b0;
            r_wr_data  <= 8'h00;
            r_wr_pend  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_rd_arm   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl_i};
            r_sda_sync <= {r_sda_sync[1:0], sda_i};
            r_scl_rise <= w_scl_rise;
            r_scl_fall <= w_scl_fall;
            r_start    <= w_start;
            r_stop     <= w_stop;
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_addr     <= w_addr;
            r_rx       <= w_rx;
            r_tx       <= w_tx;
            r_rw       <= w_rw;
            r_oe       <= w_oe;
            r_ack_on   <= w_ack_on;
            r_wr_data  <= w_wr_data;
            r_wr_pend  <= w_wr_pend;
            r_wr_valid <= r_wr_pend;
            r_rd_arm   <= w_rd_arm;
            r_rd_req   <= r_rd_arm;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_addr    = r_addr;
        w_rx      = r_rx;
        w_tx      = r_tx;
        w_rw      = r_rw;
        w_oe      = r_oe;
        w_ack_on  = r_ack_on;
        w_wr_data = r_wr_data;
        w_wr_pend = 1'b0;
        w_rd_arm  = 1'b0;
        w_busy    = r_busy;

        // requester presents the byte during the rd_req cycle
        if (r_rd_req) begin
            w_tx = rd_data;
        end

        if (r_stop) begin
            w_state  = S_IDLE;
            w_cnt    = 4'd0;
            w_oe     = 1'b0;
            w_ack_on = 1'b0;
            w_busy   = 1'b0;
        end else if (r_start) begin
            // busy survives a repeated START; the next address phase decides it
            w_state  = S_ADDR;
            w_cnt    = 4'd0;
            w_oe     = 1'b0;
            w_ack_on = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (r_scl_rise) begin
                        w_addr = w_addr_shift;
                        w_cnt  = w_cnt_inc;
                        if (r_cnt == c_ADDR_LAST) begin
                            w_state = S_RW;
                        end
                    end
                end
                S_RW: begin
                    if (r_scl_rise) begin
                        w_rw  = w_bit;
                        w_cnt = 4'd0;
                        if (r_addr == SLAVE_ADDR) begin
                            w_state = S_ADDR_ACK;
                            w_busy  = 1'b1;
                        end else begin
                            w_state = S_WAIT_STOP;
                            w_busy  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (r_scl_fall) begin
                        if (!r_ack_on) begin
                            w_oe     = 1'b1;
                            w_ack_on = 1'b1;
                            w_rd_arm = r_rw;
                        end else begin
                            w_ack_on = 1'b0;
                            if (r_rw) begin
                                w_oe    = ~r_tx[w_tx_idx];
                                w_cnt   = 4'd1;
                                w_state = S_TX_BYTE;
                            end else begin
                                w_oe    = 1'b0;
                                w_cnt   = 4'd0;
                                w_state = S_RX_BYTE;
                            end
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (r_scl_rise) begin
                        w_rx  = w_rx_shift;
                        w_cnt = w_cnt_inc;
                        if (r_cnt == 4'd7) begin
                            w_wr_data = w_rx_shift;
                            w_wr_pend = 1'b1;
                            w_ack_on  = 1'b0;
                            w_state   = S_RX_ACK;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (r_scl_fall) begin
                        if (!r_ack_on) begin
                            w_oe     = 1'b1;
                            w_ack_on = 1'b1;
                        end else begin
                            w_oe     = 1'b0;
                            w_ack_on = 1'b0;
                            w_cnt    = 4'd0;
                            w_state  = S_RX_BYTE;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (r_scl_fall) begin
                        if (r_cnt < 4'd8) begin
                            w_oe  = ~r_tx[w_tx_idx];
                            w_cnt = w_cnt_inc;
                        end else begin
                            w_oe    = 1'b0;
                            w_state = S_TX_ACK;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (r_scl_rise) begin
                        if (!w_bit) begin
                            w_rd_arm = 1'b1;
                            w_cnt    = 4'd0;
                            w_state  = S_TX_BYTE;
                        end else begin
                            w_state = S_WAIT_STOP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe   = r_oe;
    assign wr_data  = r_wr_data;
    assign wr_valid = r_wr_valid;
    assign rd_req   = r_rd_req;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_port
// Brief    : Directed bench for i2c_slave_port; bit-banged master on SDA/SCL.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_port;

    localparam int Q = 60;
`ifdef I2C_SLAVE_MSB_FIRST_EN
    localparam bit c_MSB = 1'b1;
`else
    localparam bit c_MSB = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_valid, rd_req, busy;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;

    int         n_pass = 0;
    int         n_total = 0;
    int         wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, busy_hi_cnt = 0, busy_lo_cnt = 0, both_cnt = 0;
    int         rd_base = 0;
    logic [7:0] wr_log [0:63];
    logic [7:0] rd_tbl [0:3];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_port dut (
        .CLK      (CLK),
        .RST      (RST),
        .scl_i    (m_scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (wr_valid) begin
            if (wr_cnt < 64) wr_log[wr_cnt] = wr_data;
            wr_cnt++;
        end
        if (rd_req) begin
            rd_data = rd_tbl[(rd_cnt - rd_base) & 3];
            rd_cnt++;
        end
        if (sda_oe) oe_cnt++;
        if (busy) busy_hi_cnt++; else busy_lo_cnt++;
        if (wr_valid && rd_req) both_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bit_slot(input logic b, output logic s);
        m_sda = b;
        #Q;
        m_scl = 1'b1;
        #(Q/2);
        s = sda_bus;
        #(Q/2);
        m_scl = 1'b0;
        #Q;
    endtask

    task automatic bus_start;
        m_sda = 1'b1;
        #Q;
        m_scl = 1'b1;
        #Q;
        m_sda = 1'b0;
        #Q;
        m_scl = 1'b0;
        #Q;
    endtask

    task automatic bus_stop;
        m_sda = 1'b0;
        #Q;
        m_scl = 1'b1;
        #Q;
        m_sda = 1'b1;
        #(2*Q);
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
        logic s;
        for (int i = 0; i < 7; i++) bit_slot(c_MSB ? a[6-i] : a[i], s);
        bit_slot(rw, s);
        bit_slot(1'b1, ack);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) bit_slot(c_MSB ? d[7-i] : d[i], s);
        bit_slot(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_slot(1'b1, s);
            if (c_MSB) d[7-i] = s; else d[i] = s;
        end
        bit_slot(nack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         wb, ob, bh, bl, rb;

        @(posedge CLK);
        #2;
        repeat (4) #10;
        check("rst_sda_oe",   32'(sda_oe),   32'h0);
        check("rst_wr_data",  32'(wr_data),  32'h00);
        check("rst_wr_valid", 32'(wr_valid), 32'h0);
        check("rst_rd_req",   32'(rd_req),   32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        RST = 1'b1;
        #100;

        // plain write of two bytes
        wb = wr_cnt;
        bus_start;
        send_addr(7'h2A, 1'b0, ack);
        check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy",     32'(busy), 32'h1);
        send_byte(8'hA5, ack);
        check("wr_b1_ack",   32'(ack), 32'h0);
        check("wr_b1_data",  32'(wr_data), 32'hA5);
        send_byte(8'h3C, ack);
        check("wr_b2_ack",   32'(ack), 32'h0);
        check("wr_count",    32'(wr_cnt - wb), 32'd2);
        check("wr_log0",     32'(wr_log[wb]), 32'hA5);
        check("wr_log1",     32'(wr_log[wb+1]), 32'h3C);
        bus_stop;
        check("wr_busy_stop", 32'(busy), 32'h0);

        // address miss
        wb = wr_cnt;
        ob = oe_cnt;
        bh = busy_hi_cnt;
        bus_start;
        send_addr(7'h2B, 1'b0, ack);
        check("miss_addr_nack", 32'(ack), 32'h1);
        send_byte(8'hFF, ack);
        check("miss_byte_nack", 32'(ack), 32'h1);
        bus_stop;
        check("miss_oe_never", 32'(oe_cnt - ob), 32'd0);
        check("miss_no_wr",    32'(wr_cnt - wb), 32'd0);
        check("miss_busy_low", 32'(busy_hi_cnt - bh), 32'd0);

        // read of two bytes, ACK then NACK
        rd_tbl[0] = 8'h81;
        rd_tbl[1] = 8'h7E;
        rd_base = rd_cnt;
        rb = rd_cnt;
        bus_start;
        send_addr(7'h2A, 1'b1, ack);
        check("rd_addr_ack", 32'(ack), 32'h0);
        recv_byte(1'b0, d);
        check("rd_byte1", 32'(d), 32'h81);
        recv_byte(1'b1, d);
        check("rd_byte2", 32'(d), 32'h7E);
        check("rd_released", 32'(sda_oe), 32'h0);
        check("rd_req_count", 32'(rd_cnt - rb), 32'd2);
        bus_stop;

        // write then repeated START into a read
        wb = wr_cnt;
        bus_start;
        send_addr(7'h2A, 1'b0, ack);
        check("sr_wr_ack", 32'(ack), 32'h0);
        send_byte(8'h10, ack);
        check("sr_b_ack", 32'(ack), 32'h0);
        rd_tbl[0] = 8'h55;
        rd_base = rd_cnt;
        bl = busy_lo_cnt;
        bus_start;
        send_addr(7'h2A, 1'b1, ack);
        check("sr_rd_ack", 32'(ack), 32'h0);
        check("sr_busy_held", 32'(busy_lo_cnt - bl), 32'd0);
        recv_byte(1'b1, d);
        check("sr_rd_byte", 32'(d), 32'h55);
        bus_stop;
        check("sr_wr_count", 32'(wr_cnt - wb), 32'd1);
        check("sr_wr_log",   32'(wr_log[wb]), 32'h10);

        // reset in the middle of a data byte
        wb = wr_cnt;
        bus_start;
        send_addr(7'h2A, 1'b0, ack);
        check("rm_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) bit_slot(1'b0, ack);
        RST = 1'b0;
        #20;
        check("rm_oe_rel",   32'(sda_oe), 32'h0);
        check("rm_wr_data",  32'(wr_data), 32'h00);
        RST = 1'b1;
        #Q;
        bus_stop;
        check("rm_no_wr", 32'(wr_cnt - wb), 32'd0);
        bus_start;
        send_addr(7'h2A, 1'b0, ack);
        check("rm2_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h99, ack);
        check("rm2_b_ack", 32'(ack), 32'h0);
        bus_stop;
        check("rm2_wr_count", 32'(wr_cnt - wb), 32'd1);
        check("rm2_wr_data",  32'(wr_data), 32'h99);

        check("no_wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
